// File: rtl/camera_config_sequencer_if.sv
// SCCB write-master command bundle between the config sequencer
// and the SCCB master.
interface camera_config_sequencer_if;
  logic       sccb_ready;
  logic       sccb_start;
  logic [7:0] sccb_reg;
  logic [7:0] sccb_val;
  logic       sccb_nack;

  modport master (
    input  sccb_ready,
    input  sccb_nack,
    output sccb_start,
    output sccb_reg,
    output sccb_val
  );

  modport slave (
    output sccb_ready,
    output sccb_nack,
    input  sccb_start,
    input  sccb_reg,
    input  sccb_val
  );
endinterface

// File: rtl/camera_config_sequencer.sv
// Walks the camera config ROM and issues one SCCB write per entry,
// handling delay/end escape codes and NACK retries.
module camera_config_sequencer #(
  parameter int DELAY_CYCLES = 2_500_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [7:0]                        rom_addr,
  input  logic [15:0]                       rom_data,
  camera_config_sequencer_if.master         sccb,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [CW-1:0] DLY_LOAD = CW'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [15:0] CODE_END = 16'hFFFF;
  localparam logic [15:0] CODE_DLY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_rom_addr;
  logic [15:0]   r_word;
  logic          r_fetch;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic          r_sccb_start;
  logic [7:0]    r_sccb_reg;
  logic [7:0]    r_sccb_val;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic w_is_end;
  logic w_is_dly;

  assign w_is_end = (r_word == CODE_END);
  assign w_is_dly = (r_word == CODE_DLY);

  assign rom_addr        = r_rom_addr;
  assign sccb.sccb_start = r_sccb_start;
  assign sccb.sccb_reg   = r_sccb_reg;
  assign sccb.sccb_val   = r_sccb_val;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rom_addr   <= '0;
      r_word       <= '0;
      r_fetch      <= 1'b0;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_sccb_start <= 1'b0;
      r_sccb_reg   <= '0;
      r_sccb_val   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_sccb_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_retry    <= '0;
            r_rom_addr <= '0;
            r_fetch    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        // cycle 1: ROM samples address; cycle 2: ROM output valid
        S_FETCH: begin
          if (r_fetch) begin
            r_word  <= rom_data;
            r_fetch <= 1'b0;
            r_state <= S_DECODE;
          end else begin
            r_fetch <= 1'b1;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            w_is_end: r_state <= S_DONE;
            w_is_dly: begin
              r_cnt   <= DLY_LOAD;
              r_state <= S_DELAY;
            end
            default: begin
              r_sccb_reg <= r_word[15:8];
              r_sccb_val <= r_word[7:0];
              r_state    <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: begin
          if (sccb.sccb_ready) begin
            r_sccb_start <= 1'b1;
            r_state      <= S_WAIT_ACCEPT;
          end
        end
        S_WAIT_ACCEPT: begin
          if (!sccb.sccb_ready) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (sccb.sccb_ready) begin
            if (!sccb.sccb_nack) begin
              r_retry <= '0;
              r_state <= S_NEXT;
            end else if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == '0) begin
            r_state <= S_NEXT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // address 255 is the last entry; never wrap back to 0
        S_NEXT: begin
          if (r_rom_addr == 8'hFF) begin
            r_state <= S_DONE;
          end else begin
            r_rom_addr <= r_rom_addr + 8'd1;
            r_fetch    <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/camera_config_sequencer.md
Name: camera_config_sequencer

Overview:
- Walks the camera register-configuration ROM from address 0 and issues one SCCB register write per 16-bit entry to the SCCB write master.
- Interprets ROM escape codes: 16'hFFF0 inserts a timed delay; 16'hFFFF ends the sequence.
- Sits between the config ROM and the SCCB master in the camera front end, and raises done once the sensor is configured so capture logic may start.

Parameters:
- DELAY_CYCLES, 2_500_000, clk cycles waited per 16'hFFF0 entry (100 ms at 25 MHz); minimum 1.
- MAX_RETRY, 3, extra attempts allowed per register after a NACK before aborting.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins or restarts the sequence from ROM address 0; ignored while busy=1.
- rom_addr  output  8  ROM address. Registered ROM: data is valid 1 clk after the address is sampled.
- rom_data  input  16  ROM word: [15:8] register address, [7:0] value.
- sccb_ready  input  1  SCCB master idle and able to accept a command.
- sccb_start  output  1  one-cycle command strobe to the SCCB master.
- sccb_reg  output  8  register address for the write; held stable from the strobe until the write completes.
- sccb_val  output  8  register value for the write; held stable from the strobe until the write completes.
- sccb_nack  input  1  write-failed flag; valid in the cycle sccb_ready returns high after a write.
- busy  output  1  high while the sequence is running.
- done  output  1  high once the end marker is reached; held until the next start or rst.
- error  output  1  high when the sequence is aborted after retries are exhausted; held until the next start or rst.

Behaviour:
- Reset values: rom_addr=0, sccb_start=0, sccb_reg=0, sccb_val=0, busy=0, done=0, error=0, state=IDLE, retry count=0, delay counter=0.
- IDLE: on start=1, clear done, error and the retry count; set rom_addr=0; go to FETCH; busy=1 from the next cycle.
- FETCH: lasts exactly 2 cycles with rom_addr held stable (address registered, then ROM output registered). At the end of the 2nd cycle, latch rom_data and go to DECODE.
- DECODE (1 cycle), branching on the latched word:
  - 16'hFFFF -> DONE.
  - 16'hFFF0 -> DELAY, load the counter with DELAY_CYCLES-1.
  - any other value -> sccb_reg=word[15:8], sccb_val=word[7:0], go to ISSUE.
- ISSUE: wait for sccb_ready=1. In that cycle assert sccb_start=1 for exactly 1 cycle, then go to WAIT_ACCEPT.
- WAIT_ACCEPT: wait for sccb_ready=0, then go to WAIT_DONE. sccb_start must stay 0 here; no second strobe.
- WAIT_DONE: wait for sccb_ready=1, then sample sccb_nack:
  - nack=0 -> clear the retry count, go to NEXT.
  - nack=1 and retry count < MAX_RETRY -> increment the count, return to ISSUE with the same sccb_reg/sccb_val.
  - nack=1 and retry count = MAX_RETRY -> error=1, go to IDLE (busy=0, done=0).
- DELAY: decrement the counter each cycle; at 0 go to NEXT. Total time spent in DELAY is exactly DELAY_CYCLES cycles.
- NEXT (1 cycle):
  - rom_addr=255 -> go to DONE. No wrap to 0.
  - otherwise rom_addr+1, go to FETCH.
- DONE: done=1, busy=0, return to IDLE. done stays 1 in IDLE until the next start.
- start while busy=1 is ignored; there is no abort input.
- sccb_nack is ignored in every state except the WAIT_DONE exit cycle.
- rst in any state, including mid-write or mid-delay, returns all outputs to reset values on the next edge. The SCCB master is reset by the same rst.
- The first ROM entry (sensor soft reset) is an ordinary write; the required post-reset settle time comes from the following 16'hFFF0 entry.

Test Plan:
- DELAY_CYCLES=4; ROM {0:12_80, 1:FFF0, 2:12_04, default FFFF}; SCCB model with 5-cycle write latency; pulse start -> exactly 2 sccb_start strobes, with (reg,val) = (12,80) then (12,04). The gap between the end of write 1 and the fetch of address 2 includes exactly 4 DELAY cycles. done=1 after rom_addr=3 is fetched; busy then returns to 0.
- Model holds sccb_ready=0 for 50 cycles before the first write -> sccb_start stays 0 until ready rises, then pulses once for 1 cycle.
- MAX_RETRY=3; model NACKs the write to 12_04 twice, then ACKs -> 3 strobes with identical (12,04); sequence completes with done=1, error=0.
- Model always NACKs the first write -> 4 strobes of (12,80), then error=1, busy=0, done=0, and no further ROM fetches.
- Assert rst during DELAY (counter mid-count), then pulse start -> all outputs at reset values; sequence restarts from rom_addr=0 and completes normally.
- ROM filled with non-FFFF words at all 256 addresses -> 256 writes; done after address 255, with no fetch at address 0 afterwards. A start pulse issued while busy has no effect.
